// File: rtl/board_update_ctrl_pkg.sv
// rtl/board_update_ctrl_pkg.sv - board geometry, tile codes and controller states
package board_update_ctrl_pkg;

  localparam int BOARD_W     = 32;
  localparam int BOARD_H     = 24;
  localparam int BOARD_TILES = BOARD_W * BOARD_H;

  typedef logic [9:0] addr_t;

  typedef enum logic [3:0] {
    T_EMPTY  = 4'd0,
    T_WALL   = 4'd1,
    T_PELLET = 4'd2,
    T_PAC    = 4'd3,
    T_POWER  = 4'd4
  } tile_t;

  typedef enum logic [2:0] {
    S_HOME,
    S_HOME_CLR,
    S_IDLE,
    S_READ,
    S_CHECK,
    S_CLEAR,
    S_DRAW,
    S_DONE
  } state_t;

endpackage

// File: rtl/board_update_ctrl_if.sv
// rtl/board_update_ctrl_if.sv - move handshake and Board_RAM port bundle
interface board_update_ctrl_if;
  import board_update_ctrl_pkg::*;

  logic       move_req;
  addr_t      move_target;
  logic       move_ack;
  logic       move_ok;
  addr_t      rd_addr;
  logic [3:0] rd_data;
  logic       wr_en;
  addr_t      wr_addr;
  logic [3:0] wr_data;

  modport slave (
    input  move_req, move_target, rd_data,
    output move_ack, move_ok, rd_addr, wr_en, wr_addr, wr_data
  );

  modport master (
    output move_req, move_target, rd_data,
    input  move_ack, move_ok, rd_addr, wr_en, wr_addr, wr_data
  );

endinterface

// File: rtl/board_update_ctrl_sat_add16.sv
// rtl/board_update_ctrl_sat_add16.sv - 16-bit adder clamping at 16'hFFFF
module board_update_ctrl_sat_add16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] sum
);

  logic [16:0] full;

  assign full = {1'b0, a} + {1'b0, b};
  assign sum  = full[16] ? 16'hFFFF : full[15:0];

endmodule

// File: rtl/board_update_ctrl.sv
// rtl/board_update_ctrl.sv - sole Board_RAM writer: validates moves, redraws Pac-Man, keeps score
module board_update_ctrl
  import board_update_ctrl_pkg::*;
#(
  parameter int HOME_TILE    = 495,
  parameter int PELLET_COUNT = 300,
  parameter int RAM_LAT      = 1,
  parameter int PELLET_PTS   = 10,
  parameter int POWER_PTS    = 50
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  board_update_ctrl_if.slave  bus,
  output addr_t               pac_loc,
  output logic [15:0]         score,
  output logic [9:0]          pellets_left,
  output logic                all_eaten
);

  localparam addr_t      HOME   = addr_t'(HOME_TILE);
  localparam addr_t      LAST   = addr_t'(BOARD_TILES - 1);
  localparam logic [1:0] LAT_M1 = 2'(RAM_LAT - 1);

  state_t      state, state_nx;
  addr_t       target;
  logic [1:0]  lat_cnt;
  logic        ok_q;
  logic [15:0] pts, score_sum;
  logic        is_oob, is_wall, is_pellet, is_power;

  board_update_ctrl_sat_add16 u_sat (
    .a   (score),
    .b   (pts),
    .sum (score_sum)
  );

  always_comb begin
    is_oob    = target > LAST;
    is_wall   = bus.rd_data == T_WALL;
    is_pellet = bus.rd_data == T_PELLET;
    is_power  = bus.rd_data == T_POWER;
    pts       = is_pellet ? 16'(PELLET_PTS) : (is_power ? 16'(POWER_PTS) : 16'd0);
  end

  // Strobes decode straight from state; reset masks them so an aborted move writes nothing.
  always_comb begin
    state_nx     = state;
    bus.wr_en    = 1'b0;
    bus.wr_addr  = pac_loc;
    bus.wr_data  = T_EMPTY;
    bus.move_ack = 1'b0;
    bus.move_ok  = 1'b0;
    case (state)
      S_HOME: begin
        bus.wr_en   = !reset;
        bus.wr_addr = HOME;
        bus.wr_data = T_PAC;
        state_nx    = S_IDLE;
      end
      S_HOME_CLR: begin
        bus.wr_en = !reset;
        state_nx  = S_HOME;
      end
      S_IDLE: begin
        if (start)
          state_nx = (pac_loc != HOME) ? S_HOME_CLR : S_HOME;
        else if (bus.move_req)
          state_nx = S_READ;
      end
      S_READ: begin
        if (lat_cnt == 2'd0)
          state_nx = S_CHECK;
      end
      S_CHECK: begin
        if (is_oob || is_wall || target == pac_loc)
          state_nx = S_DONE;
        else
          state_nx = S_CLEAR;
      end
      S_CLEAR: begin
        bus.wr_en = !reset;
        state_nx  = S_DRAW;
      end
      S_DRAW: begin
        bus.wr_en   = !reset;
        bus.wr_addr = target;
        bus.wr_data = T_PAC;
        state_nx    = S_DONE;
      end
      S_DONE: begin
        bus.move_ack = !reset;
        bus.move_ok  = !reset && ok_q;
        state_nx     = S_IDLE;
      end
      default: state_nx = S_HOME;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_HOME;
      pac_loc      <= HOME;
      score        <= 16'd0;
      pellets_left <= 10'(PELLET_COUNT);
      all_eaten    <= 1'b0;
      bus.rd_addr  <= '0;
      target       <= '0;
      lat_cnt      <= 2'd0;
      ok_q         <= 1'b0;
    end else begin
      state     <= state_nx;
      all_eaten <= pellets_left == 10'd0;
      case (state)
        S_IDLE: begin
          if (!start && bus.move_req) begin
            target      <= bus.move_target;
            bus.rd_addr <= bus.move_target;
            lat_cnt     <= LAT_M1;
          end
        end
        S_READ: begin
          if (lat_cnt != 2'd0)
            lat_cnt <= lat_cnt - 2'd1;
        end
        S_CHECK: begin
          if (is_oob || is_wall) begin
            ok_q <= 1'b0;
          end else begin
            ok_q <= 1'b1;
            if (target != pac_loc) begin
              score <= score_sum;
              if ((is_pellet || is_power) && pellets_left != 10'd0)
                pellets_left <= pellets_left - 10'd1;
            end
          end
        end
        S_DRAW:  pac_loc <= target;
        S_HOME:  pac_loc <= HOME;
        default: ;
      endcase
    end
  end

endmodule
